// File: rtl/fir4_out_decim_fifo_if.sv
// Stream bundle for the FIR output stage: sample input side and FIFO output side.
interface fir4_out_decim_fifo_if #(
   parameter int W     = 16,
   parameter int DEPTH = 8
);
   logic                   in_valid;
   logic [W+1:0]           in_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [W-1:0]           out_data;
   logic [$clog2(DEPTH):0] count;
   logic                   overflow;

   modport master (
      output in_valid, in_data, out_ready,
      input  out_valid, out_data, count, overflow
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output out_valid, out_data, count, overflow
   );
endinterface

// File: rtl/fir4_out_decim_fifo.sv
// FIR output stage: drop pipeline-fill samples, divide by 4 with rounding,
// decimate by DEC and queue results in a DEPTH-entry valid/ready FIFO.
module fir4_out_decim_fifo #(
   parameter int W     = 16,
   parameter int DEC   = 2,
   parameter int DEPTH = 8,
   parameter int SKIP  = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clr,
   fir4_out_decim_fifo_if.slave   bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = (DEC > 1) ? $clog2(DEC) : 1;
   localparam int SW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;

   typedef enum logic {S_SKIP, S_RUN} state_t;
   // With nothing to skip the stage starts producing immediately.
   localparam state_t S_INIT = (SKIP == 0) ? S_RUN : S_SKIP;

   state_t          state, state_n;
   logic [PW-1:0]   phase, phase_n;
   logic [SW-1:0]   skip_cnt, skip_cnt_n;
   logic            keep;

   logic [W+2:0]    sum;
   logic [W-1:0]    r;

   logic            stage_vld;
   logic [W-1:0]    stage_data;

   logic [W-1:0]    mem [DEPTH];
   logic [AW:0]     wr_ptr, rd_ptr;
   logic            full, empty, pop, wr_en;

   assign sum = {1'b0, bus.in_data} + (W+3)'(2);
   assign r   = W'(sum >> 2);

   always_comb begin
      state_n    = state;
      phase_n    = phase;
      skip_cnt_n = skip_cnt;
      keep       = 1'b0;
      if (bus.in_valid) begin
         case (state)
            S_SKIP: begin
               skip_cnt_n = skip_cnt + 1'b1;
               if (skip_cnt == SW'(SKIP - 1)) state_n = S_RUN;
            end
            S_RUN: begin
               keep    = (phase == '0);
               phase_n = (phase == PW'(DEC - 1)) ? '0 : phase + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Extra pointer MSB distinguishes full from empty when low bits match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop   = !empty && bus.out_ready;
   assign wr_en = stage_vld && (!full || pop);

   assign bus.out_valid = !empty;
   assign bus.count     = wr_ptr - rd_ptr;
   assign bus.out_data  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_INIT;
         phase        <= '0;
         skip_cnt     <= '0;
         stage_vld    <= 1'b0;
         stage_data   <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         bus.overflow <= 1'b0;
      end else if (clr) begin
         state        <= S_INIT;
         phase        <= '0;
         skip_cnt     <= '0;
         stage_vld    <= 1'b0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         bus.overflow <= 1'b0;
      end else begin
         state     <= state_n;
         phase     <= phase_n;
         skip_cnt  <= skip_cnt_n;
         stage_vld <= keep;
         if (keep) stage_data <= r;
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         if (stage_vld && full && !pop) bus.overflow <= 1'b1;
      end
   end

   // Storage has no reset; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (wr_en && !clr) mem[wr_ptr[AW-1:0]] <= stage_data;
   end
endmodule

// File: doc/fir4_out_decim_fifo.md
Name: fir4_out_decim_fifo

Overview:
Output stage placed directly downstream of the 4-tap FIR. It takes the FIR's (W+2)-bit tap sum every cycle and discards the pipeline-fill samples after reset. It scales the sum by 1/4 with round-half-up, which gives a unity-gain moving average. It then decimates by DEC and buffers the results in a small FIFO with a valid/ready interface towards the consumer.

Parameters:
- W, 16: FIR input sample width. in_data is W+2 bits; out_data is W bits.
- DEC, 2: decimation factor, range 1..16. 1 keeps every sample.
- DEPTH, 8: FIFO entries. Must be a power of 2, at least 2.
- SKIP, 5: number of accepted input samples discarded after reset or clr. This covers the FIR pipeline fill.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- clr, input, 1: synchronous soft clear, active-high.
- in_valid, input, 1: in_data valid this cycle. Tie high when fed directly by the FIR.
- in_data, input, W+2: FIR tap sum, unsigned.
- out_valid, output, 1: FIFO non-empty.
- out_ready, input, 1: consumer accepts out_data.
- out_data, output, W: head of FIFO.
- count, output, clog2(DEPTH)+1: FIFO occupancy, 0..DEPTH.
- overflow, output, 1: sticky flag; set when a kept sample is dropped because the FIFO is full.

Behaviour:
- Reset (reset=0, asynchronous): takes effect immediately, without waiting for a clock edge.
  - out_valid=0, count=0, overflow=0.
  - Pointers, stage register, phase and skip counter all cleared.
  - FSM enters S_SKIP.
  - FIFO memory is not cleared.
- Arithmetic:
  - r = (in_data + 2) >> 2, computed in W+3 bits, truncated to W bits.
  - Maximum input 4*(2^W-1) maps to 2^W-1, so saturation is not needed.
- FSM:
  - S_SKIP: each in_valid cycle increments the skip count and the sample is dropped. The cycle that accepts the SKIP-th sample moves the FSM to S_RUN. SKIP=0 enters S_RUN directly from reset.
  - S_RUN: a phase counter runs 0..DEC-1 and advances on every in_valid cycle, wrapping to 0.
    - A sample arriving with phase==0 is kept. All other samples are dropped.
    - The first sample in S_RUN has phase 0.
  - in_valid=0: no state changes at all.
- Pipeline:
  - Edge N: a kept sample loads stage_data=r and sets stage_vld=1.
  - Edge N+1: the stage is written into the FIFO.
  - out_valid first rises after edge N+1 when the FIFO was empty, so latency is 2 edges from input capture to output visibility.
- FIFO:
  - Pop occurs on an edge where out_valid && out_ready.
  - out_data = mem[rd_ptr], combinational from the read pointer. It is don't-care while out_valid=0.
  - Ordering is strictly first-in, first-out.
  - Push and pop on the same edge: count is unchanged. This is allowed at full and at empty+stage (the stage writes while the FIFO is empty, no pop).
- Full: a stage write with count==DEPTH and no simultaneous pop drops the sample and sets overflow=1.
  - overflow stays high until reset or clr.
  - FIFO contents are untouched.
- clr=1 at an edge:
  - Empties the FIFO, so count=0 and out_valid=0 after the edge.
  - Clears stage_vld, phase, skip count and overflow. FSM returns to S_SKIP.
  - A sample presented in the same cycle is dropped.
  - A pop requested in the same cycle is ignored.
- Pointers are clog2(DEPTH)+1 bits wide and wrap naturally. Full is detected by an MSB mismatch with equal low bits.

Test Plan:
1. Startup and decimation: reset release; DEC=2, SKIP=5; in_valid=1 with in_data=400 constant; out_ready=1 → the first 5 samples are dropped. Sample 6 gives out_valid high 2 edges after its capture, with out_data=100. After that, one output every 2 cycles; count never exceeds 1.
2. Rounding: in_data = 5, 6, 2, 262140 (W=16), DEC=1, SKIP=0 → out_data = 1, 2, 1, 65535, in order.
3. Overflow: out_ready=0, DEC=1, SKIP=0, feed 10 samples with values 1..10 in units of 4 → count=8. overflow=1 after the 9th write attempt. Draining yields 1..8 and nothing else.
4. Push and pop at full: FIFO holds 8 entries; assert out_ready=1 for one cycle while a stage write occurs → count stays 8, overflow stays 0. The next drain returns the new sample last.
5. clr mid-stream: FIFO holds 3 entries and overflow=1; pulse clr → next cycle count=0, out_valid=0, overflow=0. The following 5 samples are skipped again.
6. Asynchronous reset mid-operation: drive reset low between clock edges → out_valid, count and overflow go to 0 before the next rising edge. Operation resumes per scenario 1 after reset is released.
